// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART-driven program loader, step/run control and state dump for the MIPS pipeline.
// Optional step-cycle counter in the dump: define DEBUG_UNIT_CYCLE_COUNT_EN.
module debug_unit #(
    parameter int NB         = 32,
    parameter int NB_BYTE    = 8,
    parameter int N_REGS     = 32,
    parameter int DMEM_WORDS = 16,
    parameter int IMEM_WORDS = 256
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic [NB_BYTE-1:0]  o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_step,
    output logic                o_instruction_write_enable,
    output logic [NB-1:0]       o_instruction_address,
    output logic [NB-1:0]       o_instruction_data,
    output logic [4:0]          o_debug_mips_register_number,
    output logic [NB-1:0]       o_debug_address,
    input  logic [NB-1:0]       i_mips_pc,
    input  logic [NB-1:0]       i_mips_register_data,
    input  logic [NB-1:0]       i_mips_data_memory,
    input  logic                i_halt
);

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    localparam int BASE = 2;
`else
    localparam int BASE = 1;
`endif
    localparam int WORDS = BASE + N_REGS + DMEM_WORDS;
    localparam int WW    = $clog2(WORDS);
    localparam int IW    = $clog2(IMEM_WORDS);

    localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
    localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
    localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h43;
    localparam logic [NB_BYTE-1:0] ACK_BYTE = 8'h4B;

    typedef enum logic [3:0] {
        IDLE, LD_CNT, LD_BYTE, LD_WR, ACK, STEP, RUN, DUMP_SEL, DUMP_LATCH, DUMP_TX
    } state_t;

    state_t               state, next_state;
    logic [1:0]           byte_idx;
    logic [NB_BYTE-1:0]   word_cnt;
    logic [IW-1:0]        load_idx;
    logic [NB-1:0]        asm_word;
    logic [NB-1:0]        shift_word;
    logic [WW-1:0]        dump_idx;
    logic [4:0]           reg_num;
    logic [NB-1:0]        dbg_addr;
    logic [NB-1:0]        dump_word;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    logic [31:0]          cycle_count;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (i_rx_valid) begin
                if (i_rx_data == CMD_LOAD)      next_state = LD_CNT;
                else if (i_rx_data == CMD_STEP) next_state = i_halt ? DUMP_SEL : STEP;
                else if (i_rx_data == CMD_RUN)  next_state = i_halt ? DUMP_SEL : RUN;
            end
            LD_CNT:     if (i_rx_valid) next_state = (i_rx_data == '0) ? ACK : LD_BYTE;
            LD_BYTE:    if (i_rx_valid && byte_idx == 2'd3) next_state = LD_WR;
            LD_WR:      next_state = (word_cnt == 1) ? ACK : LD_BYTE;
            ACK:        if (i_tx_ready) next_state = IDLE;
            STEP:       next_state = DUMP_SEL;
            RUN:        if (i_halt) next_state = DUMP_SEL;
            DUMP_SEL:   next_state = DUMP_LATCH;
            DUMP_LATCH: next_state = DUMP_TX;
            DUMP_TX:    if (i_tx_ready && byte_idx == 2'd3)
                            next_state = (dump_idx == WW'(WORDS - 1)) ? IDLE : DUMP_SEL;
            default:    next_state = IDLE;
        endcase
    end

    // Everything except the dump selects is decoded from state, so IDLE presents all zeros.
    always_comb begin
        o_step                     = (state == STEP) || (state == RUN && !i_halt);
        o_tx_valid                 = (state == ACK) || (state == DUMP_TX);
        o_tx_data                  = '0;
        o_instruction_write_enable = (state == LD_WR);
        o_instruction_address      = '0;
        o_instruction_data         = '0;
        if (state == ACK)     o_tx_data = ACK_BYTE;
        if (state == DUMP_TX) o_tx_data = shift_word[NB_BYTE-1:0];
        if (state == LD_WR) begin
            o_instruction_address[IW+1:0] = {load_idx, 2'b00};
            o_instruction_data            = asm_word;
        end
    end

    always_comb begin
        dump_word = i_mips_data_memory;
        if (dump_idx == '0)                          dump_word = i_mips_pc;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
        else if (dump_idx == WW'(1))                 dump_word = NB'(cycle_count);
`endif
        else if (dump_idx < WW'(BASE + N_REGS))      dump_word = i_mips_register_data;
    end

    assign o_debug_mips_register_number = reg_num;
    assign o_debug_address              = dbg_addr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_idx   <= '0;
            word_cnt   <= '0;
            load_idx   <= '0;
            asm_word   <= '0;
            shift_word <= '0;
            dump_idx   <= '0;
            reg_num    <= '0;
            dbg_addr   <= '0;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
            cycle_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    byte_idx <= '0;
                    dump_idx <= '0;
                    if (i_rx_valid && i_rx_data == CMD_LOAD) begin
                        load_idx <= '0;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
                        cycle_count <= '0;
`endif
                    end
                end
                LD_CNT: if (i_rx_valid) word_cnt <= i_rx_data;
                LD_BYTE: if (i_rx_valid) begin
                    asm_word <= {i_rx_data, asm_word[NB-1:NB_BYTE]};
                    byte_idx <= byte_idx + 2'd1;
                end
                LD_WR: begin
                    word_cnt <= word_cnt - 1'b1;
                    load_idx <= load_idx + 1'b1;
                end
                DUMP_SEL: begin
                    if (dump_idx >= WW'(BASE + N_REGS))
                        dbg_addr <= NB'(dump_idx - WW'(BASE + N_REGS)) << 2;
                    else if (dump_idx >= WW'(BASE))
                        reg_num <= 5'(dump_idx - WW'(BASE));
                end
                DUMP_LATCH: begin
                    shift_word <= dump_word;
                    byte_idx   <= '0;
                end
                DUMP_TX: if (i_tx_ready) begin
                    shift_word <= shift_word >> NB_BYTE;
                    byte_idx   <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) dump_idx <= dump_idx + 1'b1;
                end
                default: ;
            endcase
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
            if (o_step) cycle_count <= cycle_count + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// tb/tb_debug_unit.sv - Table-driven and randomized bench for debug_unit against a byte-level reference model.
module tb_debug_unit;
    localparam int N_REGS = 32, DMEM_WORDS = 16;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    localparam int HAS_CNT = 1;
`else
    localparam int HAS_CNT = 0;
`endif
    localparam int DB = 4 * (1 + HAS_CNT + N_REGS + DMEM_WORDS);
    localparam int K_LOAD = 0, K_STEP = 1, K_RUN = 2;

    logic        i_clk = 0, i_reset = 1;
    logic [7:0]  i_rx_data = 0, o_tx_data;
    logic        i_rx_valid = 0, o_tx_valid, i_tx_ready = 0;
    logic        o_step, o_instruction_write_enable, i_halt = 0;
    logic [31:0] o_instruction_address, o_instruction_data, o_debug_address;
    logic [4:0]  o_debug_mips_register_number;
    logic [31:0] i_mips_pc = 0, i_mips_register_data, i_mips_data_memory;
    logic [31:0] reg_file [32];
    logic [31:0] dmem [16];

    assign i_mips_register_data = reg_file[o_debug_mips_register_number];
    assign i_mips_data_memory   = dmem[o_debug_address[5:2]];

    debug_unit dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_step(o_step),
        .o_instruction_write_enable(o_instruction_write_enable),
        .o_instruction_address(o_instruction_address), .o_instruction_data(o_instruction_data),
        .o_debug_mips_register_number(o_debug_mips_register_number),
        .o_debug_address(o_debug_address), .i_mips_pc(i_mips_pc),
        .i_mips_register_data(i_mips_register_data), .i_mips_data_memory(i_mips_data_memory),
        .i_halt(i_halt)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0, miscompares = 0;
    int step_cnt = 0;
    bit hold_ready = 0;
    logic [7:0]  tx_q [$];
    logic [63:0] wr_q [$];
    logic [31:0] model_count = 0;
    logic        pv = 0, pr = 0, pwe = 0;
    logic [7:0]  pd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Passive monitor: records transfers and write strobes, checks the tx hold rule.
    always @(negedge i_clk) begin
        if (i_reset) begin
            pv <= 0; pwe <= 0;
        end else begin
            if (pv && !pr) begin
                check("tx_hold_valid", {31'b0, o_tx_valid}, 32'd1);
                check("tx_hold_data", {24'b0, o_tx_data}, {24'b0, pd});
            end
            if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
            if (o_instruction_write_enable) begin
                wr_q.push_back({o_instruction_address, o_instruction_data});
                check("we_single_cycle", {31'b0, pwe}, 32'd0);
            end
            if (o_step) step_cnt <= step_cnt + 1;
            pv <= o_tx_valid; pr <= i_tx_ready; pd <= o_tx_data; pwe <= o_instruction_write_enable;
        end
    end

    initial begin
        forever begin
            @(posedge i_clk); #1;
            i_tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_rx(input logic [7:0] b);
        @(posedge i_clk); #1;
        i_rx_data = b; i_rx_valid = 1;
        @(posedge i_clk); #1;
        i_rx_valid = 0;
    endtask

    task automatic push_word(inout logic [7:0] q [$], input logic [31:0] w);
        for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
    endtask

    task automatic randomize_state();
        i_mips_pc = $urandom;
        for (int i = 0; i < 32; i++) reg_file[i] = $urandom;
        for (int i = 0; i < 16; i++) dmem[i] = $urandom;
    endtask

    task automatic build_dump(output logic [7:0] q [$]);
        q = {};
        push_word(q, i_mips_pc);
        if (HAS_CNT != 0) push_word(q, model_count);
        for (int i = 0; i < N_REGS; i++) push_word(q, reg_file[i]);
        for (int i = 0; i < DMEM_WORDS; i++) push_word(q, dmem[i]);
    endtask

    task automatic wait_tx(input int n);
        int budget = 0;
        while (tx_q.size() < n && budget < 20000) begin
            @(posedge i_clk); #1; budget++;
        end
        check("tx_wait_budget", {31'b0, budget >= 20000}, 32'd0);
        repeat (10) @(posedge i_clk);
        #1;
    endtask

    task automatic compare_tx(input logic [7:0] exp [$]);
        check("tx_len", tx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < tx_q.size(); i++)
            check($sformatf("tx_byte%0d", i), {24'b0, tx_q[i]}, {24'b0, exp[i]});
    endtask

    typedef struct {
        int kind; int nwords; bit halt_pre; int run_len;
        int exp_steps; int exp_tx; int exp_wr;
    } vec_t;

    task automatic apply(input vec_t v, input bit fixed);
        logic [31:0] words [$];
        logic [7:0]  exp_tx [$];
        int s0, budget;
        tx_q.delete(); wr_q.delete();
        randomize_state();
        if (fixed && v.kind == K_STEP) i_mips_pc = 32'h8;
        s0 = step_cnt;
        if (v.kind == K_LOAD) begin
            for (int i = 0; i < v.nwords; i++)
                words.push_back(fixed ? (i == 0 ? 32'h13 : 32'hFFFFFFFF) : $urandom);
            send_rx(8'h4C);
            send_rx(8'(v.nwords));
            foreach (words[i]) for (int b = 0; b < 4; b++) send_rx(words[i][8*b +: 8]);
            model_count = 0;
            exp_tx = {8'h4B};
        end else begin
            i_halt = v.halt_pre;
            send_rx(v.kind == K_STEP ? 8'h53 : 8'h43);
            if (v.kind == K_RUN && !v.halt_pre) begin
                budget = 0;
                while (step_cnt - s0 != v.run_len && budget < 1000) begin
                    @(posedge i_clk); #1; budget++;
                end
                i_halt = 1;
            end
            model_count = model_count + 32'(v.exp_steps);
            build_dump(exp_tx);
        end
        wait_tx(v.exp_tx);
        i_halt = 0;
        check("tx_count_table", tx_q.size(), v.exp_tx);
        compare_tx(exp_tx);
        check("step_count", step_cnt - s0, v.exp_steps);
        check("write_count", wr_q.size(), v.exp_wr);
        for (int i = 0; i < words.size() && i < wr_q.size(); i++) begin
            check("wr_addr", wr_q[i][63:32], 32'(4 * i));
            check("wr_data", wr_q[i][31:0], words[i]);
        end
    endtask

    vec_t tbl [10];
    logic [7:0] exp_q [$];
    int s0;

    initial begin
        tbl[0] = '{K_LOAD, 2, 0, 0, 0, 1, 2};
        tbl[1] = '{K_STEP, 0, 0, 0, 1, DB, 0};
        tbl[2] = '{K_LOAD, 0, 0, 0, 0, 1, 0};
        tbl[3] = '{K_RUN,  0, 0, 10, 10, DB, 0};
        tbl[4] = '{K_STEP, 0, 1, 0, 0, DB, 0};
        tbl[5] = '{K_RUN,  0, 1, 0, 0, DB, 0};
        tbl[6] = '{K_LOAD, 5, 0, 0, 0, 1, 5};
        tbl[7] = '{K_RUN,  0, 0, 0, 0, DB, 0};
        tbl[7].run_len   = $urandom_range(1, 20);
        tbl[7].exp_steps = tbl[7].run_len;
        tbl[8] = '{K_STEP, 0, 0, 0, 1, DB, 0};
        tbl[9] = '{K_RUN,  0, 0, 1, 1, DB, 0};

        randomize_state();
        repeat (3) @(posedge i_clk);
        #1 i_reset = 0;
        @(negedge i_clk);
        check("rst_tx_valid", {31'b0, o_tx_valid}, 32'd0);
        check("rst_tx_data", {24'b0, o_tx_data}, 32'd0);
        check("rst_step", {31'b0, o_step}, 32'd0);
        check("rst_we", {31'b0, o_instruction_write_enable}, 32'd0);
        check("rst_iaddr", o_instruction_address, 32'd0);
        check("rst_idata", o_instruction_data, 32'd0);
        check("rst_regnum", {27'b0, o_debug_mips_register_number}, 32'd0);
        check("rst_daddr", o_debug_address, 32'd0);

        // Non-command bytes in IDLE are ignored.
        tx_q.delete(); s0 = step_cnt;
        send_rx(8'h00); send_rx(8'hFF); send_rx(8'h4B);
        repeat (5) @(posedge i_clk);
        check("idle_junk_tx", tx_q.size(), 0);
        check("idle_junk_step", step_cnt - s0, 0);

        for (int i = 0; i < 10; i++) apply(tbl[i], (i < 4));

        // Backpressure mid-dump, with a step command that must be dropped.
        tx_q.delete(); randomize_state(); i_halt = 0; s0 = step_cnt;
        send_rx(8'h53);
        model_count = model_count + 1;
        build_dump(exp_q);
        for (int b = 0; b < 5000 && tx_q.size() < 20; b++) @(posedge i_clk);
        #1 hold_ready = 1;
        repeat (10) @(posedge i_clk);
        send_rx(8'h53);
        repeat (40) @(posedge i_clk);
        #1 hold_ready = 0;
        wait_tx(DB);
        compare_tx(exp_q);
        check("hold_steps", step_cnt - s0, 1);

        // Reset in the middle of a load discards it.
        wr_q.delete(); tx_q.delete();
        send_rx(8'h4C); send_rx(8'h02); send_rx(8'h13); send_rx(8'h00);
        i_reset = 1;
        @(posedge i_clk); #1 i_reset = 0;
        model_count = 0;
        @(negedge i_clk);
        check("mid_rst_we", {31'b0, o_instruction_write_enable}, 32'd0);
        check("mid_rst_tx_valid", {31'b0, o_tx_valid}, 32'd0);
        check("mid_rst_step", {31'b0, o_step}, 32'd0);
        check("mid_rst_iaddr", o_instruction_address, 32'd0);
        repeat (5) @(posedge i_clk);
        check("mid_rst_writes", wr_q.size(), 0);
        check("mid_rst_tx", tx_q.size(), 0);
        apply(tbl[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
